// File: rtl/hazard_scoreboard_unit.sv
// hazard_scoreboard_unit
// Forwarding and load-use hazard unit for the pipelined MIPS core.
// It keeps a small scoreboard of in-flight destination registers (entry 0 = EX).
// From that scoreboard it picks the ALU operand sources for the ID instruction.
// It also raises Stall when a load result cannot be forwarded yet.
// Optional feature: define HAZARD_STALL_CNT_EN to build a saturating stall
// counter on StallCount; otherwise StallCount is tied to zero.
module hazard_scoreboard_unit #(
  parameter int REG_AW     = 5,
  parameter int DEPTH      = 3,
  parameter int LOAD_AVAIL = 1
) (
  input  logic                              CLK,
  input  logic                              Reset,
  input  logic                              ID_Valid,
  input  logic [REG_AW-1:0]                 ID_Rs,
  input  logic [REG_AW-1:0]                 ID_Rt,
  input  logic                              UseShamt,
  input  logic                              UseImmed,
  input  logic [REG_AW-1:0]                 ID_Rw,
  input  logic                              ID_RegWrite,
  input  logic                              ID_MemRead,
  input  logic                              Flush,
  input  logic                              Freeze,
  output logic [$clog2(DEPTH+2)-1:0]        AluOpCtrlA,
  output logic [$clog2(DEPTH+2)-1:0]        AluOpCtrlB,
  output logic                              Stall,
  output logic [31:0]                       StallCount
);

  localparam int SW = $clog2(DEPTH+2);
  localparam logic [SW-1:0] SEL_REGFILE = SW'(DEPTH + 1);
  localparam logic [SW-1:0] SEL_ALT     = '0;

  // Scoreboard storage: one {valid, rw, load} triple per in-flight stage.
  logic [DEPTH-1:0]             valid_q, valid_d;
  logic [DEPTH-1:0][REG_AW-1:0] rw_q, rw_d;
  logic [DEPTH-1:0]             load_q, load_d;

  // Per-operand lookup results.
  logic            hitA, hitB;
  logic [SW-1:0]   fwdSelA, fwdSelB;
  logic            lateLoadA, lateLoadB;
  logic            usedA, usedB;
  logic            hazardA, hazardB;
  logic            issue;

  // Youngest-match search: scan oldest to youngest so the lowest index wins last.
  always_comb begin
    hitA      = 1'b0;
    hitB      = 1'b0;
    fwdSelA   = SEL_REGFILE;
    fwdSelB   = SEL_REGFILE;
    lateLoadA = 1'b0;
    lateLoadB = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (valid_q[k] && (rw_q[k] == ID_Rs) && (ID_Rs != '0)) begin
        hitA      = 1'b1;
        fwdSelA   = SW'(k + 1);
        lateLoadA = load_q[k] && (k < LOAD_AVAIL);
      end
      if (valid_q[k] && (rw_q[k] == ID_Rt) && (ID_Rt != '0)) begin
        hitB      = 1'b1;
        fwdSelB   = SW'(k + 1);
        lateLoadB = load_q[k] && (k < LOAD_AVAIL);
      end
    end
  end

  // Load-use detection and operand-select resolution; a stall parks both selects on the register file.
  always_comb begin
    usedA   = ID_Valid && !UseShamt;
    usedB   = ID_Valid && !UseImmed;
    hazardA = usedA && hitA && lateLoadA;
    hazardB = usedB && hitB && lateLoadB;
    Stall   = hazardA || hazardB;
    if (Stall) begin
      AluOpCtrlA = SEL_REGFILE;
      AluOpCtrlB = SEL_REGFILE;
    end else begin
      AluOpCtrlA = UseShamt ? SEL_ALT : fwdSelA;
      AluOpCtrlB = UseImmed ? SEL_ALT : fwdSelB;
    end
  end

  // Next scoreboard contents: shift toward older stages and insert the ID instruction or a bubble.
  always_comb begin
    issue   = ID_Valid && ID_RegWrite && (ID_Rw != '0) && !Stall && !Flush;
    valid_d = valid_q;
    rw_d    = rw_q;
    load_d  = load_q;
    if (!Freeze) begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        valid_d[k] = valid_q[k-1];
        rw_d[k]    = rw_q[k-1];
        load_d[k]  = load_q[k-1];
      end
      valid_d[0] = issue;
      rw_d[0]    = issue ? ID_Rw : '0;
      load_d[0]  = issue && ID_MemRead;
    end
  end

  // Scoreboard register update; reset clears every in-flight entry and beats Freeze.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      valid_q <= '0;
      rw_q    <= '0;
      load_q  <= '0;
    end else begin
      valid_q <= valid_d;
      rw_q    <= rw_d;
      load_q  <= load_d;
    end
  end

`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] stallCount_q, stallCount_d;

  // Saturating count of cycles that actually stalled the pipe.
  always_comb begin
    stallCount_d = stallCount_q;
    if (Stall && !Freeze && (stallCount_q != 32'hFFFF_FFFF)) begin
      stallCount_d = stallCount_q + 32'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      stallCount_q <= '0;
    end else begin
      stallCount_q <= stallCount_d;
    end
  end

  assign StallCount = stallCount_q;
`else
  assign StallCount = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// tb_hazard_scoreboard_unit
// Self-checking bench for hazard_scoreboard_unit (DEPTH=3, LOAD_AVAIL=1).
// The reference model keeps a list of issued instructions tagged with their age in cycles.
module tb_hazard_scoreboard_unit;

  localparam int REG_AW     = 5;
  localparam int DEPTH      = 3;
  localparam int LOAD_AVAIL = 1;
  localparam int SW         = $clog2(DEPTH + 2);

  logic              CLK = 1'b0;
  logic              Reset;
  logic              ID_Valid;
  logic [REG_AW-1:0] ID_Rs, ID_Rt, ID_Rw;
  logic              UseShamt, UseImmed;
  logic              ID_RegWrite, ID_MemRead;
  logic              Flush, Freeze;
  logic [SW-1:0]     AluOpCtrlA, AluOpCtrlB;
  logic              Stall;
  logic [31:0]       StallCount;

  typedef struct {
    logic [REG_AW-1:0] rw;
    bit                isLoad;
    int                age;
  } inflight_t;

  inflight_t   flight[$];
  logic [31:0] modelCount;
  int          assertCount = 0;
  int          failCount   = 0;

  hazard_scoreboard_unit #(
    .REG_AW(REG_AW), .DEPTH(DEPTH), .LOAD_AVAIL(LOAD_AVAIL)
  ) dut (
    .CLK(CLK), .Reset(Reset), .ID_Valid(ID_Valid), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
    .UseShamt(UseShamt), .UseImmed(UseImmed), .ID_Rw(ID_Rw),
    .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead), .Flush(Flush),
    .Freeze(Freeze), .AluOpCtrlA(AluOpCtrlA), .AluOpCtrlB(AluOpCtrlB),
    .Stall(Stall), .StallCount(StallCount)
  );

  always #5 CLK = ~CLK;

  // Single comparison point: counts and reports.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0d, expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  // Age of the most recently issued in-flight writer of r, or -1.
  function automatic int youngestAge(input logic [REG_AW-1:0] r, output bit isLoad);
    int best = -1;
    isLoad = 1'b0;
    if (r == '0) return -1;
    foreach (flight[i]) begin
      if (flight[i].rw == r && (best < 0 || flight[i].age < best)) begin
        best   = flight[i].age;
        isLoad = flight[i].isLoad;
      end
    end
    return best;
  endfunction

  function automatic bit operandHazard(input bit used, input logic [REG_AW-1:0] r);
    bit ld;
    int age;
    age = youngestAge(r, ld);
    return used && (age >= 0) && ld && (age < LOAD_AVAIL);
  endfunction

  function automatic bit modelStall();
    return operandHazard(ID_Valid && !UseShamt, ID_Rs) || operandHazard(ID_Valid && !UseImmed, ID_Rt);
  endfunction

  function automatic logic [31:0] modelSel(input bit useAlt, input logic [REG_AW-1:0] r);
    bit ld;
    int age;
    if (modelStall()) return DEPTH + 1;
    if (useAlt) return 0;
    age = youngestAge(r, ld);
    return (age >= 0) ? age + 1 : DEPTH + 1;
  endfunction

  function automatic logic [31:0] expectedCount();
`ifdef HAZARD_STALL_CNT_EN
    return modelCount;
`else
    return 32'd0;
`endif
  endfunction

  // One clock cycle with the currently driven inputs: check outputs, then advance the model.
  task automatic applyStimulus();
    bit        stallNow;
    bit        issue;
    inflight_t item;
    #1;
    stallNow = modelStall();
    checkOutput("AluOpCtrlA", 32'(AluOpCtrlA), modelSel(UseShamt, ID_Rs));
    checkOutput("AluOpCtrlB", 32'(AluOpCtrlB), modelSel(UseImmed, ID_Rt));
    checkOutput("Stall", 32'(Stall), 32'(stallNow));
    @(posedge CLK);
    if (Reset) begin
      flight.delete();
      modelCount = 0;
    end else if (!Freeze) begin
      if (stallNow && modelCount != 32'hFFFF_FFFF) modelCount++;
      foreach (flight[i]) flight[i].age++;
      for (int i = flight.size() - 1; i >= 0; i--) begin
        if (flight[i].age >= DEPTH) flight.delete(i);
      end
      issue = ID_Valid && ID_RegWrite && (ID_Rw != '0) && !stallNow && !Flush;
      if (issue) begin
        item.rw     = ID_Rw;
        item.isLoad = ID_MemRead;
        item.age    = 0;
        flight.push_back(item);
      end
    end
    #1;
    checkOutput("StallCount", StallCount, expectedCount());
  endtask

  task automatic setIdle();
    Reset = 0; ID_Valid = 0; ID_Rs = 0; ID_Rt = 0; ID_Rw = 0;
    UseShamt = 0; UseImmed = 0; ID_RegWrite = 0; ID_MemRead = 0;
    Flush = 0; Freeze = 0;
  endtask

  task automatic doReset();
    setIdle();
    Reset = 1;
    applyStimulus();
    Reset = 0;
  endtask

  task automatic issueOp(input logic [REG_AW-1:0] rw, input bit isLoad);
    setIdle();
    ID_Valid = 1; ID_RegWrite = 1; ID_Rw = rw; ID_MemRead = isLoad;
    applyStimulus();
  endtask

  task automatic presentUse(input logic [REG_AW-1:0] rs, input logic [REG_AW-1:0] rt);
    setIdle();
    ID_Valid = 1; ID_Rs = rs; ID_Rt = rt;
  endtask

  initial begin
    modelCount = 0;
    setIdle();
    Reset = 1;
    @(posedge CLK);
    #1;
    Reset = 0;

    // Empty scoreboard after reset.
    presentUse(5, 0);
    #1;
    checkOutput("reset_selA", 32'(AluOpCtrlA), 4);
    checkOutput("reset_stall", 32'(Stall), 0);
    checkOutput("reset_count", StallCount, 0);
    UseShamt = 1; UseImmed = 1;
    #1;
    checkOutput("reset_shamt", 32'(AluOpCtrlA), 0);
    checkOutput("reset_immed", 32'(AluOpCtrlB), 0);
    applyStimulus();

    // ALU result ages through every stage and then leaves.
    doReset();
    issueOp(5, 0);
    for (int k = 1; k <= 4; k++) begin
      presentUse(5, 0);
      #1;
      checkOutput("age_selA", 32'(AluOpCtrlA), 32'(k));
      applyStimulus();
    end

    // Youngest writer wins.
    doReset();
    issueOp(5, 0);
    issueOp(5, 0);
    presentUse(5, 5);
    #1;
    checkOutput("young_selA", 32'(AluOpCtrlA), 1);
    checkOutput("young_selB", 32'(AluOpCtrlB), 1);
    applyStimulus();

    // Load-use stall for one cycle, then forward from entry 1.
    doReset();
    issueOp(7, 1);
    presentUse(0, 7);
    #1;
    checkOutput("lu_stall", 32'(Stall), 1);
    checkOutput("lu_selB_stall", 32'(AluOpCtrlB), 4);
    applyStimulus();
    presentUse(0, 7);
    #1;
    checkOutput("lu_stall_clear", 32'(Stall), 0);
    checkOutput("lu_selB_fwd", 32'(AluOpCtrlB), 2);
`ifdef HAZARD_STALL_CNT_EN
    checkOutput("lu_count", StallCount, 1);
`else
    checkOutput("lu_count", StallCount, 0);
`endif
    applyStimulus();

    // Immediate operand hides the load.
    doReset();
    issueOp(7, 1);
    presentUse(0, 7);
    UseImmed = 1;
    #1;
    checkOutput("imm_selB", 32'(AluOpCtrlB), 0);
    checkOutput("imm_stall", 32'(Stall), 0);
    applyStimulus();

    // r0 is never tracked.
    doReset();
    issueOp(0, 0);
    presentUse(0, 0);
    #1;
    checkOutput("r0_selA", 32'(AluOpCtrlA), 4);
    applyStimulus();

    // Freeze holds the scoreboard.
    doReset();
    issueOp(5, 0);
    for (int k = 0; k < 3; k++) begin
      presentUse(5, 0);
      Freeze = 1;
      #1;
      checkOutput("freeze_selA", 32'(AluOpCtrlA), 1);
      applyStimulus();
    end

    // Flush keeps the instruction out.
    doReset();
    setIdle();
    ID_Valid = 1; ID_RegWrite = 1; ID_Rw = 6; Flush = 1;
    applyStimulus();
    presentUse(6, 0);
    #1;
    checkOutput("flush_selA", 32'(AluOpCtrlA), 4);
    applyStimulus();

    // Randomized traffic against the model.
    doReset();
    for (int n = 0; n < 600; n++) begin
      Reset       = ($urandom_range(0, 99) < 2);
      ID_Valid    = ($urandom_range(0, 99) < 80);
      ID_Rs       = REG_AW'($urandom_range(0, 7));
      ID_Rt       = REG_AW'($urandom_range(0, 7));
      ID_Rw       = REG_AW'($urandom_range(0, 7));
      UseShamt    = ($urandom_range(0, 99) < 15);
      UseImmed    = ($urandom_range(0, 99) < 25);
      ID_RegWrite = ($urandom_range(0, 99) < 70);
      ID_MemRead  = ($urandom_range(0, 99) < 35);
      Flush       = ($urandom_range(0, 99) < 10);
      Freeze      = ($urandom_range(0, 99) < 10);
      applyStimulus();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard_unit.md
# hazard_scoreboard_unit

Parametrised forwarding and load-use hazard unit for the pipelined MIPS core. It replaces comparisons against fixed EX/MEM destination ports with an internal scoreboard of in-flight destination registers, DEPTH entries deep. From that scoreboard it resolves the ALU operand source for the instruction in ID and raises a stall on load-use hazards. It sits in the ID stage, beside the register file, and drives the ID/EX operand-select registers and the IF/ID hold logic.

## Interface
- REG_AW, default 5: register address width.
- DEPTH, default 3: number of in-flight stages tracked after ID (entry 0 = EX). Legal range 1..8.
- LOAD_AVAIL, default 1: load data can be forwarded only from entries with index ≥ LOAD_AVAIL. Legal range 0..DEPTH-1.
- SW, default $clog2(DEPTH+2): operand-select width. Derived; not overridden.

- CLK  in  1  clock; all state updates on its rising edge.
- Reset  in  1  synchronous, active-high reset.
- ID_Valid  in  1  the instruction in ID is real (not a bubble).
- ID_Rs, ID_Rt  in  REG_AW  source registers of the ID instruction.
- UseShamt  in  1  operand A is the shift amount, not Rs.
- UseImmed  in  1  operand B is the immediate, not Rt.
- ID_Rw  in  REG_AW  destination register of the ID instruction.
- ID_RegWrite  in  1  the ID instruction writes ID_Rw.
- ID_MemRead  in  1  the ID instruction is a load.
- Flush  in  1  kill the ID instruction; it does not enter the scoreboard.
- Freeze  in  1  global pipeline hold; the scoreboard does not change.
- AluOpCtrlA, AluOpCtrlB  out  SW  source select for operands A and B.
- Stall  out  1  load-use hazard; hold IF/ID and insert a bubble into EX.
- StallCount  out  32  count of stall cycles (see Configuration).

## Operation
- Scoreboard: DEPTH entries, each holding {valid, rw, load}.
- On each rising edge with Freeze=0:
  - entry k takes the contents of entry k-1, for k = 1..DEPTH-1; entry DEPTH-1 is discarded.
  - entry 0 takes {1, ID_Rw, ID_MemRead} when ID_Valid & ID_RegWrite & (ID_Rw≠0) & !Stall & !Flush. Otherwise entry 0 takes a bubble (valid=0).
- With Freeze=1, all entries hold. Freeze overrides Flush and Stall.
- Match rule for an operand register r: entry k matches when valid & (rw == r) & (r ≠ 0). The lowest-index (youngest) match wins.
- Operand-select encoding:
  - 0: shamt (A) or immediate (B).
  - k+1: forward from entry k.
  - DEPTH+1: register file.
- AluOpCtrlA:
  - 0 if UseShamt.
  - else k+1 for the youngest match on ID_Rs.
  - else DEPTH+1.
- AluOpCtrlB: same rule, using UseImmed and ID_Rt.
- An operand is used when ID_Valid=1 and its Use* input is 0.
- Hazard: a used operand's youngest match is an entry with load=1 and index < LOAD_AVAIL.
- Stall = 1 on a hazard on A or B. While Stall=1, both AluOpCtrl outputs read DEPTH+1.
- All outputs except StallCount are combinational from the scoreboard and the ID inputs.

## Timing
- Reset (synchronous): all entries invalid, StallCount=0.
- Output values with the scoreboard empty after reset:
  - Stall=0.
  - AluOpCtrlA = 0 if UseShamt, else DEPTH+1.
  - AluOpCtrlB = 0 if UseImmed, else DEPTH+1.
- Reset asserted mid-operation clears all in-flight entries at that edge. Reset has priority over Freeze.
- An instruction issued at edge t is entry 0 during cycle t..t+1 and entry k during cycle t+k..t+k+1, provided there is no Freeze. It leaves the scoreboard after DEPTH cycles.
- Stall has zero latency, in the same cycle as the ID inputs. A stalled instruction re-presents at the next cycle, by which time the load has moved to entry index+1. Total stall length is LOAD_AVAIL − index cycles.
- Simultaneous Flush and Stall: a bubble is inserted; Stall is still reported.

## Configuration
- HAZARD_STALL_CNT_EN defined:
  - StallCount increments by 1 at each edge where Stall=1, Freeze=0 and Reset=0.
  - Saturates at 32'hFFFF_FFFF.
- Not defined: StallCount is tied to 0 and no counter register is inferred.

## Test plan
All scenarios use DEPTH=3, LOAD_AVAIL=1, HAZARD_STALL_CNT_EN defined.
- Reset, then ID_Valid=1, ID_Rs=5, UseShamt=0, no prior issue -> AluOpCtrlA=4, Stall=0, StallCount=0.
- Issue an ALU op writing r5; the next three cycles present ID_Rs=5 with no further issues -> AluOpCtrlA = 1, 2, 3, then 4.
- Issue two ALU ops writing r5 on consecutive cycles, then present ID_Rs=5 and ID_Rt=5 -> AluOpCtrlA=1, AluOpCtrlB=1 (youngest wins).
- Issue a load writing r7; the next cycle presents ID_Rt=7, UseImmed=0:
  - first cycle -> Stall=1, AluOpCtrlB=4.
  - following cycle -> Stall=0, AluOpCtrlB=2.
  - StallCount=1.
- Issue a load to r7, then present ID_Rt=7 with UseImmed=1 -> AluOpCtrlB=0, Stall=0.
- Issue a write to r0, then present ID_Rs=0 -> AluOpCtrlA=4.
- Issue a write to r5, then hold Freeze=1 for 3 cycles -> AluOpCtrlA stays 1.
- Flush=1 together with a valid write to r6, then present ID_Rs=6 next cycle -> AluOpCtrlA=4.
